// File: rtl/kernel_window_ctrl.sv
// kernel_window_ctrl: gates AXIS pixels into the 5x5 receiver, tracks col/row,
// and flags receiver outputs that hold a fully populated kernel.
//
// Ports:
//   i_clk, i_aresetn         clock, async active-low reset
//   IMAGE_WIDTH/HEIGHT [12:0] frame size, sampled at SOF
//   i_en                     1 = accept stream, 0 = backpressure
//   i_tvalid/i_tuser/i_tlast AXIS slave valid / start-of-frame / end-of-line
//   o_tready                 AXIS ready (= i_en)
//   o_rx_data_valid/o_rx_sof receiver data-valid / start-of-frame (comb)
//   o_kernel_valid           kernel complete (reg, aligned with receiver out)
//   o_center_x/o_center_y    kernel centre coords (reg)
//   o_eol/o_eof              last pixel of line / frame forwarded (reg)
//   o_busy                   state != IDLE
//   o_cfg_err                sticky: SOF with illegal size
//   o_sync_err               sticky: mid-frame SOF (or tlast mismatch)
//
// Option: KWIN_TLAST_CHECK_EN enables the tlast vs. column check.
module kernel_window_ctrl #(
  parameter int KERNEL_SIZE      = 5,
  parameter int MAX_IMAGE_WIDTH  = 4096,
  parameter int MAX_IMAGE_HEIGHT = 4096
) (
  input  logic        i_clk,
  input  logic        i_aresetn,
  input  logic [12:0] IMAGE_WIDTH,
  input  logic [12:0] IMAGE_HEIGHT,
  input  logic        i_en,
  input  logic        i_tvalid,
  input  logic        i_tuser,
  input  logic        i_tlast,
  output logic        o_tready,
  output logic        o_rx_data_valid,
  output logic        o_rx_sof,
  output logic        o_kernel_valid,
  output logic [12:0] o_center_x,
  output logic [12:0] o_center_y,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_busy,
  output logic        o_cfg_err,
  output logic        o_sync_err
);

  localparam logic [12:0] KS   = 13'(KERNEL_SIZE);
  localparam logic [12:0] KM1  = 13'(KERNEL_SIZE - 1);
  localparam logic [12:0] HALF = 13'(KERNEL_SIZE / 2);
  localparam logic [12:0] MW   = 13'(MAX_IMAGE_WIDTH);
  localparam logic [12:0] MH   = 13'(MAX_IMAGE_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] w_q;
  logic [12:0] h_q;
  logic [12:0] col;
  logic [12:0] row;

  logic        accept;
  logic        size_ok;
  logic        fwd;
  logic        sof_fwd;
  logic [12:0] pc;
  logic [12:0] pr;
  logic [12:0] pw;
  logic [12:0] ph;
  logic        last_col;
  logic        last_row;

`ifndef KWIN_TLAST_CHECK_EN
  logic        tlast_unused;
  assign tlast_unused = i_tlast;
`endif

  assign o_tready = i_en;
  assign accept   = i_tvalid & i_en;

  assign size_ok = (IMAGE_WIDTH > KS) && (IMAGE_WIDTH <= MW) &&
                   (IMAGE_HEIGHT >= KS) && (IMAGE_HEIGHT <= MH);

  assign fwd = accept & ((state == RUN) |
                         ((state == IDLE) & i_tuser & size_ok));
  assign sof_fwd = fwd & i_tuser;

  assign o_rx_data_valid = fwd;
  assign o_rx_sof        = sof_fwd;
  assign o_busy          = (state != IDLE);

  // An SOF beat always sits at (0,0) of the newly sampled frame size,
  // whatever the counters held before.
  always_comb begin
    pc = col;
    pr = row;
    pw = w_q;
    ph = h_q;
    if (sof_fwd) begin
      pc = '0;
      pr = '0;
      pw = IMAGE_WIDTH;
      ph = IMAGE_HEIGHT;
    end
  end

  assign last_col = (pc == pw - 13'd1);
  assign last_row = (pr == ph - 13'd1);

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state          <= IDLE;
      w_q            <= '0;
      h_q            <= '0;
      col            <= '0;
      row            <= '0;
      o_kernel_valid <= 1'b0;
      o_center_x     <= '0;
      o_center_y     <= '0;
      o_eol          <= 1'b0;
      o_eof          <= 1'b0;
      o_cfg_err      <= 1'b0;
      o_sync_err     <= 1'b0;
    end else begin
      o_kernel_valid <= 1'b0;
      o_eol          <= 1'b0;
      o_eof          <= 1'b0;

      if (fwd) begin
        o_kernel_valid <= (pc >= KM1) && (pr >= KM1);
        o_center_x     <= pc - HALF;
        o_center_y     <= pr - HALF;
        o_eol          <= last_col;
        o_eof          <= last_col & last_row;
      end

      if (accept && i_tuser && !size_ok && state != DONE)
        o_cfg_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (sof_fwd) begin
            w_q   <= IMAGE_WIDTH;
            h_q   <= IMAGE_HEIGHT;
            col   <= 13'd1;
            row   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (fwd && i_tuser) begin
            o_sync_err <= 1'b1;
            if (size_ok) begin
              w_q <= IMAGE_WIDTH;
              h_q <= IMAGE_HEIGHT;
              col <= 13'd1;
              row <= '0;
            end else begin
              col   <= '0;
              row   <= '0;
              state <= IDLE;
            end
          end else if (fwd) begin
`ifdef KWIN_TLAST_CHECK_EN
            if (i_tlast != last_col)
              o_sync_err <= 1'b1;
`endif
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= DONE;
              end else begin
                row <= row + 13'd1;
              end
            end else begin
              col <= col + 13'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// tb_kernel_window_ctrl: directed scenarios for kernel_window_ctrl,
// K=5, W=10, H=8 unless a scenario overrides the frame size.
module tb_kernel_window_ctrl;

  logic        clk;
  logic        rst_n;
  logic [12:0] img_w;
  logic [12:0] img_h;
  logic        en;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;
  logic        rx_dv;
  logic        rx_sof;
  logic        kv;
  logic [12:0] cx;
  logic [12:0] cy;
  logic        eol;
  logic        eof;
  logic        busy;
  logic        cfg_err;
  logic        sync_err;

  int tests;
  int failed;
  int flag_cnt;
  int first_p;
  int tw;
  int th;

  kernel_window_ctrl dut (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .IMAGE_WIDTH    (img_w),
    .IMAGE_HEIGHT   (img_h),
    .i_en           (en),
    .i_tvalid       (tvalid),
    .i_tuser        (tuser),
    .i_tlast        (tlast),
    .o_tready       (tready),
    .o_rx_data_valid(rx_dv),
    .o_rx_sof       (rx_sof),
    .o_kernel_valid (kv),
    .o_center_x     (cx),
    .o_center_y     (cy),
    .o_eol          (eol),
    .o_eof          (eof),
    .o_busy         (busy),
    .o_cfg_err      (cfg_err),
    .o_sync_err     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends pixels first..last of a tw x th frame (pixel 0 carries tuser).
  // Optional idle cycles (tvalid low or i_en low) before each beat.
  task automatic run_frame(input int first, input int last,
                           input bit gaps, input int bad_tlast);
    for (int p = first; p <= last; p++) begin
      int c;
      int r;
      logic [28:0] got_v;
      logic [28:0] exp_v;
      logic        ekv;
      logic        eeol;
      logic        eeof;
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          @(negedge clk);
          tuser = 1'b0;
          tlast = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            tvalid = 1'b0;
            en     = 1'b1;
          end else begin
            tvalid = 1'b1;
            en     = 1'b0;
          end
          #1;
          tests++;
          if (rx_dv !== 1'b0 || tready !== en) begin
            failed++;
            $display("FAIL gap_rx p=%0d rx_dv=%b tready=%b want 0/%b",
                     p, rx_dv, tready, en);
          end
          @(posedge clk);
          #1;
          tests++;
          if ({kv, eol, eof} !== 3'b000) begin
            failed++;
            $display("FAIL gap_flags p=%0d got %b want 000",
                     p, {kv, eol, eof});
          end
        end
      end
      c = p % tw;
      r = p / tw;
      @(negedge clk);
      en     = 1'b1;
      tvalid = 1'b1;
      tuser  = (p == 0);
      tlast  = (c == tw - 1) || (p == bad_tlast);
      #1;
      tests++;
      if (rx_dv !== 1'b1 || rx_sof !== (p == 0)) begin
        failed++;
        $display("FAIL beat_rx p=%0d dv=%b sof=%b want 1/%b",
                 p, rx_dv, rx_sof, (p == 0));
      end
      @(posedge clk);
      #1;
      ekv   = (c >= 4) && (r >= 4);
      eeol  = (c == tw - 1);
      eeof  = eeol && (r == th - 1);
      exp_v = {ekv, eeol, eeof,
               ekv ? 13'(c - 2) : 13'd0,
               ekv ? 13'(r - 2) : 13'd0};
      got_v = {kv, eol, eof,
               kv ? cx : 13'd0,
               kv ? cy : 13'd0};
      tests++;
      if (got_v !== exp_v) begin
        failed++;
        $display("FAIL beat_flags p=%0d got kv%b eol%b eof%b (%0d,%0d) want kv%b eol%b eof%b (%0d,%0d)",
                 p, got_v[28], got_v[27], got_v[26], got_v[25:13],
                 got_v[12:0], ekv, eeol, eeof, exp_v[25:13], exp_v[12:0]);
      end
      if (kv === 1'b1) begin
        if (flag_cnt == 0) first_p = p;
        flag_cnt++;
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    en     = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    en     = 1'b1;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    img_w  = 13'd10;
    img_h  = 13'd8;
    tw     = 10;
    th     = 8;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({kv, cx, cy, eol, eof, busy, cfg_err, sync_err, rx_dv} !== '0) begin
      failed++;
      $display("FAIL reset_outs got %h want 0",
               {kv, cx, cy, eol, eof, busy, cfg_err, sync_err, rx_dv});
    end
    @(negedge clk);
    rst_n = 1'b1;
    flag_cnt = 0;
    run_frame(0, 29, 1'b0, -1);
    tests++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL busy_mid got %b want 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({kv, cx, cy, eol, eof, busy, cfg_err, sync_err} !== '0) begin
      failed++;
      $display("FAIL reset_mid got %h want 0",
               {kv, cx, cy, eol, eof, busy, cfg_err, sync_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame;
    flag_cnt = 0;
    first_p  = -1;
    run_frame(0, 79, 1'b0, -1);
    tests++;
    if (flag_cnt !== 24 || first_p !== 44) begin
      failed++;
      $display("FAIL full_count got %0d first %0d want 24 first 44",
               flag_cnt, first_p);
    end
    // back at the negedge after the cycle following beat 79: state DONE
    tests++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL busy_done got %b want 1", busy);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_drop_no_sof;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tuser  = 1'b0;
      #1;
      tests++;
      if (rx_dv !== 1'b0 || tready !== 1'b1) begin
        failed++;
        $display("FAIL drop_rx i=%0d dv=%b tready=%b want 0/1",
                 i, rx_dv, tready);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if ({busy, kv} !== 2'b00) begin
      failed++;
      $display("FAIL drop_state got %b want 00", {busy, kv});
    end
    flag_cnt = 0;
    run_frame(0, 79, 1'b0, -1);
    tests++;
    if (flag_cnt !== 24) begin
      failed++;
      $display("FAIL drop_count got %0d want 24", flag_cnt);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_gaps;
    flag_cnt = 0;
    first_p  = -1;
    run_frame(0, 79, 1'b1, -1);
    tests++;
    if (flag_cnt !== 24 || first_p !== 44) begin
      failed++;
      $display("FAIL gaps_count got %0d first %0d want 24 first 44",
               flag_cnt, first_p);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_tlast;
    flag_cnt = 0;
    run_frame(0, 79, 1'b0, 28);
    tests++;
    if (flag_cnt !== 24) begin
      failed++;
      $display("FAIL tlast_count got %0d want 24", flag_cnt);
    end
`ifdef KWIN_TLAST_CHECK_EN
    tests++;
    if (sync_err !== 1'b1) begin
      failed++;
      $display("FAIL tlast_err got %b want 1", sync_err);
    end
`else
    tests++;
    if (sync_err !== 1'b0) begin
      failed++;
      $display("FAIL tlast_err got %b want 0", sync_err);
    end
`endif
    repeat (2) @(posedge clk);
  endtask

  task automatic test_min_size;
    img_w = 13'd6;
    img_h = 13'd5;
    tw    = 6;
    th    = 5;
    flag_cnt = 0;
    first_p  = -1;
    run_frame(0, 29, 1'b0, -1);
    tests++;
    if (flag_cnt !== 2 || first_p !== 28) begin
      failed++;
      $display("FAIL min_count got %0d first %0d want 2 first 28",
               flag_cnt, first_p);
    end
    repeat (2) @(posedge clk);
    img_w = 13'd10;
    img_h = 13'd8;
    tw    = 10;
    th    = 8;
  endtask

  task automatic test_midframe_sof;
    flag_cnt = 0;
    run_frame(0, 29, 1'b0, -1);
    flag_cnt = 0;
    first_p  = -1;
    run_frame(0, 79, 1'b0, -1);
    tests++;
    if (sync_err !== 1'b1) begin
      failed++;
      $display("FAIL midsof_err got %b want 1", sync_err);
    end
    tests++;
    if (flag_cnt !== 24 || first_p !== 44) begin
      failed++;
      $display("FAIL midsof_count got %0d first %0d want 24 first 44",
               flag_cnt, first_p);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_cfg_err;
    tests++;
    if (cfg_err !== 1'b0) begin
      failed++;
      $display("FAIL cfg_pre got %b want 0", cfg_err);
    end
    @(negedge clk);
    img_w  = 13'd5;
    tvalid = 1'b1;
    tuser  = 1'b1;
    #1;
    tests++;
    if (rx_dv !== 1'b0 || rx_sof !== 1'b0) begin
      failed++;
      $display("FAIL cfg_rx dv=%b sof=%b want 0/0", rx_dv, rx_sof);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({cfg_err, busy, kv} !== 3'b100) begin
      failed++;
      $display("FAIL cfg_state got %b want 100", {cfg_err, busy, kv});
    end
    @(negedge clk);
    tvalid = 1'b0;
    tuser  = 1'b0;
    img_w  = 13'd10;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_full_frame();
    test_drop_no_sof();
    test_gaps();
    test_tlast();
    test_min_size();
    test_midframe_sof();
    test_cfg_err();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
